// File: rtl/pipe_mem_stage.sv
// MEM stage of the 16-bit pipeline: issues data-memory accesses over a req/ready bus,
// stalls upstream while an access is outstanding, resolves branches and holds the MEM/WB register.
module pipe_mem_stage #(
    parameter int          ADDR_W         = 16,
    parameter int unsigned TIMEOUT_CYCLES = 64
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [15:0]       mem_alu_result,
    input  logic [15:0]       mem_rs2_data,
    input  logic [3:0]        mem_rd,
    input  logic              mem_reg_write,
    input  logic              mem_mem_read,
    input  logic              mem_mem_write,
    input  logic              mem_mem_to_reg,
    input  logic              mem_branch,
    input  logic              mem_branch_ne,
    input  logic              mem_zero,
    output logic              dmem_req,
    output logic              dmem_we,
    output logic [ADDR_W-1:0] dmem_addr,
    output logic [15:0]       dmem_wdata,
    input  logic              dmem_ready,
    input  logic [15:0]       dmem_rdata,
    output logic              mem_stall,
    output logic              branch_taken,
    output logic [15:0]       branch_target,
    output logic [15:0]       wb_result,
    output logic [3:0]        wb_rd,
    output logic              wb_reg_write,
    output logic              mem_fault,
    output logic [1:0]        dbg_state
);

    // Handshake: dmem_req stays high with addr/we/wdata stable until the first cycle
    // dmem_ready is sampled high; that cycle completes the access (and carries rdata for reads).
    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    localparam int CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST =
        CNT_W'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               req_q, req_d;
    logic               we_q, we_d;
    logic [ADDR_W-1:0]  addr_q, addr_d;
    logic [15:0]        wdata_q, wdata_d;
    logic [15:0]        rdata_q, rdata_d;
    logic               tout_q, tout_d;
    logic               fault_q, fault_d;
    logic [15:0]        wb_result_q, wb_result_d;
    logic [3:0]         wb_rd_q, wb_rd_d;
    logic               wb_we_q, wb_we_d;

    logic mem_op;
    logic conflict;
    logic stall;

    always_comb begin
        mem_op   = mem_mem_read ^ mem_mem_write;
        conflict = mem_mem_read & mem_mem_write;
        stall    = ((state_q == S_IDLE) && mem_op) || (state_q == S_REQ);

        state_d     = state_q;
        cnt_d       = cnt_q;
        req_d       = req_q;
        we_d        = we_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        rdata_d     = rdata_q;
        tout_d      = tout_q;
        fault_d     = fault_q | conflict;
        wb_result_d = wb_result_q;
        wb_rd_d     = wb_rd_q;
        wb_we_d     = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (mem_op) begin
                    req_d   = 1'b1;
                    we_d    = mem_mem_write;
                    addr_d  = mem_alu_result[ADDR_W-1:0];
                    wdata_d = mem_rs2_data;
                    cnt_d   = '0;
                    tout_d  = 1'b0;
                    state_d = S_REQ;
                end
            end
            S_REQ: begin
                if (dmem_ready) begin
                    req_d = 1'b0;
                    if (!we_q) rdata_d = dmem_rdata;
                    state_d = S_DONE;
                end else if ((TIMEOUT_CYCLES != 0) && (cnt_q == CNT_LAST)) begin
                    // A timed-out load retires with zero data and no register write.
                    req_d   = 1'b0;
                    fault_d = 1'b1;
                    tout_d  = 1'b1;
                    rdata_d = 16'h0000;
                    state_d = S_DONE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        if (!stall) begin
            wb_rd_d     = mem_rd;
            wb_result_d = mem_mem_to_reg ? rdata_q : mem_alu_result;
            wb_we_d     = mem_reg_write & ~conflict & ~((state_q == S_DONE) & tout_q);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            req_q       <= 1'b0;
            we_q        <= 1'b0;
            addr_q      <= '0;
            wdata_q     <= 16'h0000;
            rdata_q     <= 16'h0000;
            tout_q      <= 1'b0;
            fault_q     <= 1'b0;
            wb_result_q <= 16'h0000;
            wb_rd_q     <= 4'h0;
            wb_we_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            req_q       <= req_d;
            we_q        <= we_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            rdata_q     <= rdata_d;
            tout_q      <= tout_d;
            fault_q     <= fault_d;
            wb_result_q <= wb_result_d;
            wb_rd_q     <= wb_rd_d;
            wb_we_q     <= wb_we_d;
        end
    end

    assign dmem_req      = req_q;
    assign dmem_we       = we_q;
    assign dmem_addr     = addr_q;
    assign dmem_wdata    = wdata_q;
    assign mem_stall     = stall;
    assign branch_taken  = (mem_branch & mem_zero) | (mem_branch_ne & ~mem_zero);
    assign branch_target = mem_alu_result;
    assign wb_result     = wb_result_q;
    assign wb_rd         = wb_rd_q;
    assign wb_reg_write  = wb_we_q;
    assign mem_fault     = fault_q;
    assign dbg_state     = state_q;

endmodule

// File: tb/tb_pipe_mem_stage.sv
// Directed bench for pipe_mem_stage: table of pass-through/branch vectors plus
// hand-written load, store, timeout, conflict, reset and back-to-back sequences.
module tb_pipe_mem_stage;

    logic        clk;
    logic        rst_n;
    logic [15:0] mem_alu_result;
    logic [15:0] mem_rs2_data;
    logic [3:0]  mem_rd;
    logic        mem_reg_write, mem_mem_read, mem_mem_write, mem_mem_to_reg;
    logic        mem_branch, mem_branch_ne, mem_zero;
    logic        dmem_req, dmem_we;
    logic [15:0] dmem_addr, dmem_wdata;
    logic        dmem_ready;
    logic [15:0] dmem_rdata;
    logic        mem_stall, branch_taken;
    logic [15:0] branch_target, wb_result;
    logic [3:0]  wb_rd;
    logic        wb_reg_write, mem_fault;
    logic [1:0]  dbg_state;

    int n_checks = 0;
    int n_pass   = 0;
    int wr_cnt   = 0;

    pipe_mem_stage #(.ADDR_W(16), .TIMEOUT_CYCLES(4)) dut (
        .clk(clk), .rst_n(rst_n),
        .mem_alu_result(mem_alu_result), .mem_rs2_data(mem_rs2_data), .mem_rd(mem_rd),
        .mem_reg_write(mem_reg_write), .mem_mem_read(mem_mem_read),
        .mem_mem_write(mem_mem_write), .mem_mem_to_reg(mem_mem_to_reg),
        .mem_branch(mem_branch), .mem_branch_ne(mem_branch_ne), .mem_zero(mem_zero),
        .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr),
        .dmem_wdata(dmem_wdata), .dmem_ready(dmem_ready), .dmem_rdata(dmem_rdata),
        .mem_stall(mem_stall), .branch_taken(branch_taken), .branch_target(branch_target),
        .wb_result(wb_result), .wb_rd(wb_rd), .wb_reg_write(wb_reg_write),
        .mem_fault(mem_fault), .dbg_state(dbg_state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] alu;
        logic [15:0] rs2;
        logic [3:0]  rd;
        logic        rw, mrd, mwr, m2r, br, bne, z;
        logic        exp_taken;
        logic [15:0] exp_result;
        logic        exp_we;
    } vec_t;

    vec_t vecs[8];

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%04h expected 0x%04h", name, act, exp);
    endtask

    task automatic drive(input vec_t v);
        mem_alu_result = v.alu;
        mem_rs2_data   = v.rs2;
        mem_rd         = v.rd;
        mem_reg_write  = v.rw;
        mem_mem_read   = v.mrd;
        mem_mem_write  = v.mwr;
        mem_mem_to_reg = v.m2r;
        mem_branch     = v.br;
        mem_branch_ne  = v.bne;
        mem_zero       = v.z;
    endtask

    function automatic vec_t mk(input logic [15:0] alu, input logic [15:0] rs2, input logic [3:0] rd,
                                input logic rw, input logic mrd, input logic mwr, input logic m2r);
        vec_t v;
        v = '{alu: alu, rs2: rs2, rd: rd, rw: rw, mrd: mrd, mwr: mwr, m2r: m2r,
              br: 1'b0, bne: 1'b0, z: 1'b0, exp_taken: 1'b0, exp_result: 16'h0, exp_we: 1'b0};
        return v;
    endfunction

    // One clock: advance to the next falling edge and count retiring register writes.
    task automatic tick();
        @(posedge clk);
        @(negedge clk);
        if (wb_reg_write) wr_cnt++;
    endtask

    // Called #1 after inputs are applied; runs until the stage stops stalling.
    // wait_n < 0 means memory never answers.
    task automatic run_access(input int wait_n, input logic [15:0] rdata,
                              output int stalls, output int reqs);
        bit done = 0;
        stalls = 0;
        reqs   = 0;
        for (int c = 0; c < 40; c++) begin
            if (!mem_stall) begin
                done = 1;
                break;
            end
            stalls++;
            if (dmem_req) reqs++;
            dmem_ready = dmem_req && (wait_n >= 0) && (reqs == wait_n + 1);
            dmem_rdata = dmem_ready ? rdata : 16'hDEAD;
            tick();
            dmem_ready = 1'b0;
            #1;
        end
        if (!done) begin
            n_checks++;
            $display("FAIL access_bound: stall still high after 40 cycles");
        end
    endtask

    initial begin
        int st, rq, w0;
        vec_t v;

        vecs[0] = mk(16'h0100, 16'h0, 4'd1, 1'b0, 1'b0, 1'b0, 1'b0);
        vecs[0].bne = 1'b1; vecs[0].z = 1'b0; vecs[0].exp_taken = 1'b1;
        vecs[1] = mk(16'h0100, 16'h0, 4'd2, 1'b0, 1'b0, 1'b0, 1'b0);
        vecs[1].bne = 1'b1; vecs[1].z = 1'b1; vecs[1].exp_taken = 1'b0;
        vecs[2] = mk(16'h0200, 16'h0, 4'd3, 1'b0, 1'b0, 1'b0, 1'b0);
        vecs[2].br = 1'b1; vecs[2].z = 1'b1; vecs[2].exp_taken = 1'b1;
        vecs[3] = mk(16'h0204, 16'h0, 4'd4, 1'b0, 1'b0, 1'b0, 1'b0);
        vecs[3].br = 1'b1; vecs[3].z = 1'b0; vecs[3].exp_taken = 1'b0;
        vecs[4] = mk(16'h0300, 16'h0, 4'd5, 1'b0, 1'b0, 1'b0, 1'b0);
        vecs[4].br = 1'b1; vecs[4].bne = 1'b1; vecs[4].z = 1'b0; vecs[4].exp_taken = 1'b1;
        vecs[5] = mk(16'h0304, 16'h0, 4'd6, 1'b0, 1'b0, 1'b0, 1'b0);
        vecs[5].br = 1'b1; vecs[5].bne = 1'b1; vecs[5].z = 1'b1; vecs[5].exp_taken = 1'b1;
        vecs[6] = mk(16'hA5A5, 16'h1111, 4'd7, 1'b1, 1'b0, 1'b0, 1'b0);
        vecs[6].exp_we = 1'b1;
        vecs[7] = mk(16'h0FF0, 16'h2222, 4'd15, 1'b1, 1'b0, 1'b0, 1'b0);
        vecs[7].z = 1'b1; vecs[7].exp_we = 1'b1;
        for (int i = 0; i < 8; i++) vecs[i].exp_result = vecs[i].alu;

        drive(mk(16'h0, 16'h0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0));
        dmem_ready = 1'b0;
        dmem_rdata = 16'h0;
        rst_n = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check("rst_req", dmem_req, 0);
        check("rst_fault", mem_fault, 0);
        check("rst_wb_we", wb_reg_write, 0);
        check("rst_wb_result", wb_result, 16'h0);
        check("rst_state", dbg_state, 0);
        rst_n = 1'b1;
        tick();

        // Load 0x0040, ready on 4th REQ cycle
        drive(mk(16'h0040, 16'h0, 4'd5, 1'b1, 1'b1, 1'b0, 1'b1));
        #1;
        run_access(3, 16'hBEEF, st, rq);
        check("ld_stalls", st, 5);
        check("ld_reqs", rq, 4);
        check("ld_addr", dmem_addr, 16'h0040);
        check("ld_we", dmem_we, 0);
        tick(); #1;
        check("ld_wb_result", wb_result, 16'hBEEF);
        check("ld_wb_rd", wb_rd, 5);
        check("ld_wb_we", wb_reg_write, 1);

        // Store 0x1234 @0x0010, ready on first REQ cycle
        drive(mk(16'h0010, 16'h1234, 4'd0, 1'b0, 1'b0, 1'b1, 1'b0));
        #1;
        run_access(0, 16'h5555, st, rq);
        check("st_stalls", st, 2);
        check("st_reqs", rq, 1);
        check("st_we", dmem_we, 1);
        check("st_wdata", dmem_wdata, 16'h1234);
        check("st_addr", dmem_addr, 16'h0010);
        tick(); #1;
        check("st_wb_we", wb_reg_write, 0);

        for (int i = 0; i < 8; i++) begin
            drive(vecs[i]);
            #1;
            check($sformatf("vec%0d_taken", i), branch_taken, vecs[i].exp_taken);
            check($sformatf("vec%0d_target", i), branch_target, vecs[i].alu);
            check($sformatf("vec%0d_stall", i), mem_stall, 0);
            tick(); #1;
            check($sformatf("vec%0d_wb_result", i), wb_result, vecs[i].exp_result);
            check($sformatf("vec%0d_wb_rd", i), wb_rd, vecs[i].rd);
            check($sformatf("vec%0d_wb_we", i), wb_reg_write, vecs[i].exp_we);
            check($sformatf("vec%0d_req", i), dmem_req, 0);
        end

        // Back-to-back loads then an ALU op
        w0 = wr_cnt;
        drive(mk(16'h0020, 16'h0, 4'd1, 1'b1, 1'b1, 1'b0, 1'b1));
        #1;
        run_access(0, 16'h1111, st, rq);
        tick(); #1;
        check("b2b_a_result", wb_result, 16'h1111);
        check("b2b_a_rd", wb_rd, 1);
        drive(mk(16'h0022, 16'h0, 4'd2, 1'b1, 1'b1, 1'b0, 1'b1));
        #1;
        run_access(1, 16'h2222, st, rq);
        check("b2b_b_stalls", st, 3);
        tick(); #1;
        check("b2b_b_result", wb_result, 16'h2222);
        check("b2b_b_rd", wb_rd, 2);
        drive(mk(16'h0007, 16'h0, 4'd3, 1'b1, 1'b0, 1'b0, 1'b0));
        #1;
        check("b2b_alu_stall", mem_stall, 0);
        tick(); #1;
        check("b2b_alu_result", wb_result, 16'h0007);
        check("b2b_alu_rd", wb_rd, 3);
        check("b2b_alu_we", wb_reg_write, 1);
        drive(mk(16'h0, 16'h0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0));
        tick(); #1;
        check("b2b_writes", wr_cnt - w0, 3);
        check("b2b_req_idle", dmem_req, 0);

        // Read+write conflict
        drive(mk(16'h0055, 16'h0, 4'd4, 1'b1, 1'b1, 1'b1, 1'b0));
        #1;
        check("cf_stall", mem_stall, 0);
        check("cf_fault_before", mem_fault, 0);
        tick(); #1;
        check("cf_wb_we", wb_reg_write, 0);
        check("cf_fault", mem_fault, 1);
        check("cf_req", dmem_req, 0);

        // Reset in the middle of an outstanding request
        drive(mk(16'h0077, 16'h0, 4'd6, 1'b1, 1'b1, 1'b0, 1'b1));
        tick(); tick(); #1;
        check("mr_req_before", dmem_req, 1);
        check("mr_state_before", dbg_state, 1);
        #1;
        rst_n = 1'b0;
        #1;
        check("mr_req", dmem_req, 0);
        check("mr_state", dbg_state, 0);
        check("mr_fault", mem_fault, 0);
        check("mr_addr", dmem_addr, 16'h0);
        check("mr_wb_rd", wb_rd, 0);
        drive(mk(16'h0, 16'h0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0));
        @(negedge clk);
        rst_n = 1'b1;
        tick(); #1;
        check("mr_no_retry", dmem_req, 0);

        // Load that never gets ready
        drive(mk(16'h0080, 16'h0, 4'd9, 1'b1, 1'b1, 1'b0, 1'b1));
        #1;
        run_access(-1, 16'h0, st, rq);
        check("to_stalls", st, 5);
        check("to_reqs", rq, 4);
        check("to_req_low", dmem_req, 0);
        check("to_fault", mem_fault, 1);
        tick(); #1;
        check("to_wb_we", wb_reg_write, 0);
        check("to_wb_result", wb_result, 16'h0000);
        check("to_wb_rd", wb_rd, 9);
        drive(mk(16'h0042, 16'h0, 4'd3, 1'b1, 1'b0, 1'b0, 1'b0));
        #1;
        check("to_resume_stall", mem_stall, 0);
        tick(); #1;
        check("to_resume_we", wb_reg_write, 1);
        check("to_resume_result", wb_result, 16'h0042);
        check("to_fault_sticky", mem_fault, 1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
